// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared constants, enums and lane requantization helper for ppu_requant
package ppu_pkg;

  localparam int LANES      = 16;
  localparam int ACC_W      = 24;
  localparam int OUT_W      = 8;
  localparam int FIFO_DEPTH = 32;
  localparam int SCALE_W    = 16;
  localparam int SHIFT_W    = 5;
  localparam int ROW_W      = 4;
  localparam int PROD_W     = ACC_W + SCALE_W + 1;

  typedef enum logic [1:0] {
    MODE_INT8     = 2'd0,
    MODE_INT4     = 2'd1,
    MODE_INT4_VSQ = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_e;

  // One guard bit above the product so the rounding bias can never wrap.
  localparam logic signed [PROD_W:0] SAT8_HI = (PROD_W+1)'(127);
  localparam logic signed [PROD_W:0] SAT8_LO = (PROD_W+1)'(-128);
  localparam logic signed [PROD_W:0] SAT4_HI = (PROD_W+1)'(7);
  localparam logic signed [PROD_W:0] SAT4_LO = (PROD_W+1)'(-8);

  // Round-half-up shift, saturate to the mode's range, then optional ReLU.
  function automatic logic [OUT_W-1:0] requant_lane(
    input logic signed [PROD_W-1:0] prod,
    input logic [SHIFT_W-1:0]       shift,
    input mode_e                    mode,
    input logic                     relu
  );
    logic signed [PROD_W:0] wide;
    logic signed [PROD_W:0] bias;
    logic signed [PROD_W:0] res;
    logic signed [PROD_W:0] hi;
    logic signed [PROD_W:0] lo;
    wide = {prod[PROD_W-1], prod};
    bias = '0;
    if (shift != '0) bias[shift - SHIFT_W'(1)] = 1'b1;
    res = (wide + bias) >>> shift;
    if (mode == MODE_INT4 || mode == MODE_INT4_VSQ) begin
      hi = SAT4_HI;
      lo = SAT4_LO;
    end else begin
      hi = SAT8_HI;
      lo = SAT8_LO;
    end
    if (res > hi) res = hi;
    else if (res < lo) res = lo;
    if (relu && res[PROD_W]) res = '0;
    return res[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/ppu_requant_if.sv
// rtl/ppu_requant_if.sv - accumulator-row input, config and quantized-row output bundle
interface ppu_requant_if #(
  parameter int LANES = ppu_pkg::LANES,
  parameter int ACC_W = ppu_pkg::ACC_W
);
  logic                   i_start;
  logic [1:0]             i_mode;
  logic [LANES*ACC_W-1:0] i_acc_data;
  logic [15:0]            i_scale;
  logic [4:0]             i_shift;
  logic                   i_relu;
  logic                   i_clr_ovf;
  logic                   i_ready;
  logic [LANES*8-1:0]     o_data;
  logic [3:0]             o_row;
  logic                   o_valid;
  logic                   o_busy;
  logic                   o_overflow;

  modport slave (
    input  i_start, i_mode, i_acc_data, i_scale, i_shift, i_relu, i_clr_ovf, i_ready,
    output o_data, o_row, o_valid, o_busy, o_overflow
  );

  modport master (
    output i_start, i_mode, i_acc_data, i_scale, i_shift, i_relu, i_clr_ovf, i_ready,
    input  o_data, o_row, o_valid, o_busy, o_overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with full/empty flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  // A pop frees the slot this cycle, so a write on full is accepted alongside it.
  assign do_rd   = i_rd_en & ~o_empty;
  assign do_wr   = i_wr_en & (~o_full | do_rd);
  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_rd_data = o_empty ? '0 : mem_q[rd_ptr_q];

  // Row storage, no reset needed since occupancy gates what is visible.
  always_ff @(posedge i_clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= i_wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/ppu_requant.sv
// rtl/ppu_requant.sv - tile capture, two-stage per-lane requantization and output row FIFO
module ppu_requant
  import ppu_pkg::*;
#(
  parameter int LANES      = ppu_pkg::LANES,
  parameter int ACC_W      = ppu_pkg::ACC_W,
  parameter int FIFO_DEPTH = ppu_pkg::FIFO_DEPTH
) (
  input  logic         i_clk,
  input  logic         i_rst,
  ppu_requant_if.slave bus
);
  localparam int DATA_W = LANES * OUT_W;

  state_e               state_q;
  logic [ROW_W-1:0]     row_q;
  mode_e                mode_q;
  logic [SCALE_W-1:0]   scale_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic                 relu_q;
  logic                 ovf_q;

  logic                 s1_valid_q;
  logic [ROW_W-1:0]     s1_row_q;
  logic                 s2_valid_q;
  logic [ROW_W-1:0]     s2_row_q;
  logic [DATA_W-1:0]    s2_data;

  logic                 capture;
  logic                 pop;
  logic                 drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_W+ROW_W-1:0] fifo_rd;

  assign capture = (state_q == ST_CAPTURE);

  // Capture sequencer: latch config on start, then count 16 sampled rows.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      mode_q  <= MODE_INT8;
      scale_q <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            state_q <= ST_CAPTURE;
            row_q   <= '0;
            mode_q  <= mode_e'(bus.i_mode);
            scale_q <= bus.i_scale;
            shift_q <= bus.i_shift;
            relu_q  <= bus.i_relu;
          end
        end
        ST_CAPTURE: begin
          row_q <= row_q + ROW_W'(1);
          if (row_q == '1) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Row-index and valid tags travelling alongside the lane datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_row_q   <= '0;
    end else begin
      s1_valid_q <= capture;
      s1_row_q   <= row_q;
      s2_valid_q <= s1_valid_q;
      s2_row_q   <= s1_row_q;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic [OUT_W-1:0]         q_q;

    assign acc    = bus.i_acc_data[g*ACC_W +: ACC_W];
    assign prod_d = PROD_W'(acc) * PROD_W'($signed({1'b0, scale_q}));
    assign s2_data[g*OUT_W +: OUT_W] = q_q;

    // Stage 1: full-precision product of the sampled lane.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) prod_q <= '0;
      else if (capture) prod_q <= prod_d;
    end

    // Stage 2: round, shift, saturate and ReLU.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) q_q <= '0;
      else if (s1_valid_q) q_q <= requant_lane(prod_q, shift_q, mode_q, relu_q);
    end
  end

  assign pop  = ~fifo_empty & bus.i_ready;
  assign drop = s2_valid_q & fifo_full & ~pop;

  // Sticky overflow: a new start during capture or a dropped row; set beats clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ovf_q <= 1'b0;
    else if ((bus.i_start & capture) | drop) ovf_q <= 1'b1;
    else if (bus.i_clr_ovf) ovf_q <= 1'b0;
  end

  sync_fifo #(
    .WIDTH(DATA_W + ROW_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (s2_valid_q),
    .i_wr_data ({s2_row_q, s2_data}),
    .i_rd_en   (bus.i_ready),
    .o_rd_data (fifo_rd),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  assign bus.o_data     = fifo_rd[DATA_W-1:0];
  assign bus.o_row      = fifo_rd[DATA_W +: ROW_W];
  assign bus.o_valid    = ~fifo_empty;
  assign bus.o_busy     = capture | s1_valid_q | s2_valid_q;
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_ppu_requant.sv
// tb/tb_ppu_requant.sv - scoreboard bench for ppu_requant
module tb_ppu_requant;
  logic clk;
  logic rst;

  ppu_requant_if bus ();

  ppu_requant dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int r0_cyc = 0;
  int first_cyc = 0;
  bit seen_first = 0;
  logic [127:0] last_data = '0;
  logic [131:0] exp_q[$];

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] exp_lane(input int lane, input int scale, input int shift,
                                          input int mode, input bit relu);
    longint p, num, den, q, hi, lo;
    logic [63:0] qb;
    p = longint'(lane) * longint'(scale);
    if (shift == 0) q = p;
    else begin
      den = longint'(1) << shift;
      num = p + den / 2;
      q = num / den;
      if ((num % den) != 0 && num < 0) q = q - 1;
    end
    if (mode == 1 || mode == 2) begin hi = 7; lo = -8; end
    else begin hi = 127; lo = -128; end
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    if (relu && q < 0) q = 0;
    qb = q;
    return qb[7:0];
  endfunction

  // Samples outputs mid-cycle, scores any accepted row, then advances one clock.
  task automatic tick();
    logic [131:0] e;
    @(negedge clk);
    if (bus.o_valid && !seen_first) begin
      seen_first = 1;
      first_cyc = cyc;
    end
    if (bus.o_valid && bus.i_ready) begin
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_row: got row %0d expected no output", bus.o_row);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("o_row", 132'(bus.o_row), 132'(e[131:128]));
        chk("o_data", 132'(bus.o_data), 132'(e[127:0]));
        last_data = bus.o_data;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_tile(input logic [1:0] m, input int sc, input int sh, input bit rl,
                          input int a, input int b, input int c, input int d,
                          input bit rnd, input bit push, input int dup_row, input int abort_row);
    int pat[4];
    int v;
    logic [383:0] acc;
    logic [127:0] dat;
    logic [23:0] v24;
    pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = d;
    bus.i_start = 1'b1;
    bus.i_mode = m;
    bus.i_scale = 16'(sc);
    bus.i_shift = 5'(sh);
    bus.i_relu = rl;
    tick();
    bus.i_start = 1'b0;
    bus.i_mode = ~m;
    bus.i_scale = ~16'(sc);
    bus.i_shift = ~5'(sh);
    bus.i_relu = ~rl;
    for (int r = 0; r < 16; r++) begin
      for (int g = 0; g < 16; g++) begin
        if (rnd) v = int'($urandom_range(0, 24'hFFFFFF)) - 8388608;
        else v = pat[g % 4];
        v24 = 24'(v);
        acc[g*24 +: 24] = v24;
        dat[g*8 +: 8] = exp_lane(v, sc, sh, int'(m), rl);
      end
      bus.i_acc_data = acc;
      bus.i_start = (r == dup_row);
      bus.i_clr_ovf = (r == dup_row);
      if (r == 0) r0_cyc = cyc;
      if (r == abort_row) begin
        rst = 1'b1;
        break;
      end
      if (push) exp_q.push_back({4'(r), dat});
      tick();
    end
    bus.i_start = 1'b0;
    bus.i_clr_ovf = 1'b0;
    bus.i_acc_data = '0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.o_valid || bus.o_busy) && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_done", 132'(n < maxc), 132'(1));
    chk("busy_idle", 132'(bus.o_busy), 132'(0));
  endtask

  logic [127:0] hold_d;
  logic [3:0] hold_r;
  int n;

  initial begin
    rst = 1'b1;
    bus.i_start = 0; bus.i_mode = 0; bus.i_acc_data = '0; bus.i_scale = 0;
    bus.i_shift = 0; bus.i_relu = 0; bus.i_clr_ovf = 0; bus.i_ready = 0;
    tick(); tick();
    chk("rst_valid", 132'(bus.o_valid), 132'(0));
    chk("rst_data", 132'(bus.o_data), 132'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 132'(bus.o_valid), 132'(0));
    chk("post_rst_data", 132'(bus.o_data), 132'(0));
    chk("post_rst_row", 132'(bus.o_row), 132'(0));
    chk("post_rst_busy", 132'(bus.o_busy), 132'(0));
    chk("post_rst_ovf", 132'(bus.o_overflow), 132'(0));

    // INT8 unity pass-through and latency.
    bus.i_ready = 1'b1;
    seen_first = 0;
    run_tile(2'd0, 1, 0, 0, 100, 100, 100, 100, 0, 1, -1, -1);
    drain(100);
    chk("latency", 132'(first_cyc - r0_cyc), 132'(3));
    chk("int8_lane0", 132'(last_data[7:0]), 132'(8'h64));
    chk("ovf_clean", 132'(bus.o_overflow), 132'(0));

    // INT8 rounding and saturation.
    run_tile(2'd0, 3, 2, 0, -7, 1000, -7, 1000, 0, 1, -1, -1);
    drain(100);
    chk("round_neg", 132'(last_data[7:0]), 132'(8'hFB));
    chk("clamp_pos", 132'(last_data[15:8]), 132'(8'h7F));

    // INT4 with and without ReLU.
    run_tile(2'd1, 1, 0, 1, 9, -20, 5, 9, 0, 1, -1, -1);
    drain(100);
    chk("int4_relu", 132'(last_data[23:0]), 132'(24'h05_00_07));
    run_tile(2'd1, 1, 0, 0, 9, -20, 5, 9, 0, 1, -1, -1);
    drain(100);
    chk("int4_norelu", 132'(last_data[23:0]), 132'(24'h05_F8_07));

    // Random rows across modes and shift extremes.
    run_tile(2'd2, int'($urandom_range(1, 65535)), 6, 0, 0, 0, 0, 0, 1, 1, -1, -1);
    run_tile(2'd0, int'($urandom_range(1, 65535)), 10, 1, 0, 0, 0, 0, 1, 1, -1, -1);
    run_tile(2'd3, 65535, 31, 0, 0, 0, 0, 0, 1, 1, -1, -1);
    run_tile(2'd0, int'($urandom_range(0, 65535)), 17, 0, 0, 0, 0, 0, 1, 1, -1, -1);
    drain(150);
    chk("ovf_still_clean", 132'(bus.o_overflow), 132'(0));

    // Restart during capture row 5 with a coincident clear: set wins, 16 rows only.
    run_tile(2'd0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 5, -1);
    chk("dup_start_ovf", 132'(bus.o_overflow), 132'(1));
    drain(100);
    bus.i_clr_ovf = 1'b1; tick(); bus.i_clr_ovf = 1'b0;
    chk("ovf_cleared", 132'(bus.o_overflow), 132'(0));

    // Backpressure: two tiles fill the FIFO, the third is dropped.
    bus.i_ready = 1'b0;
    run_tile(2'd0, 5, 3, 0, 0, 0, 0, 0, 1, 1, -1, -1);
    run_tile(2'd1, 9, 4, 1, 0, 0, 0, 0, 1, 1, -1, -1);
    run_tile(2'd0, 7, 2, 0, 0, 0, 0, 0, 1, 0, -1, -1);
    n = 0;
    while (bus.o_busy && n < 50) begin tick(); n++; end
    chk("fill_settle", 132'(n < 50), 132'(1));
    chk("drop_ovf", 132'(bus.o_overflow), 132'(1));
    chk("full_valid", 132'(bus.o_valid), 132'(1));
    hold_d = bus.o_data;
    hold_r = bus.o_row;
    tick(); tick(); tick();
    chk("stall_data", 132'(bus.o_data), 132'(hold_d));
    chk("stall_row", 132'(bus.o_row), 132'(hold_r));
    bus.i_clr_ovf = 1'b1; tick(); bus.i_clr_ovf = 1'b0;
    chk("drop_ovf_cleared", 132'(bus.o_overflow), 132'(0));
    bus.i_ready = 1'b1;
    drain(200);

    // Reset at capture row 8 with rows queued behind a stalled consumer.
    bus.i_ready = 1'b0;
    run_tile(2'd0, 2, 1, 0, 0, 0, 0, 0, 1, 0, -1, 8);
    tick(); tick();
    chk("midrst_valid", 132'(bus.o_valid), 132'(0));
    chk("midrst_busy", 132'(bus.o_busy), 132'(0));
    rst = 1'b0;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("after_rst_valid", 132'(bus.o_valid), 132'(0));
    end
    chk("after_rst_busy", 132'(bus.o_busy), 132'(0));
    chk("after_rst_ovf", 132'(bus.o_overflow), 132'(0));
    run_tile(2'd0, int'($urandom_range(1, 65535)), 8, 0, 0, 0, 0, 0, 1, 1, -1, -1);
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
